// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - sequencer for an add-and-count multiplier (A, B down-counter, P accumulator)
// Optional feature macro: MUL_CTRL_CYCLE_CNT_EN adds the acc_cycles output and counter.
module mul_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        eqz,
   output logic        ldA,
   output logic        ldB,
   output logic        clrP,
   output logic        ldP,
   output logic        decB,
   output logic        busy,
`ifdef MUL_CTRL_CYCLE_CNT_EN
   output logic        done,
   output logic [15:0] acc_cycles
`else
   output logic        done
`endif
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDA  = 3'd1,
      LDB  = 3'd2,
      ACC  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state;
   state_t state_next;

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode; ACC decodes eqz combinationally so the
   // final accumulate is never issued against an already-zero B.
   always_comb begin
      state_next = state;
      ldA        = 1'b0;
      ldB        = 1'b0;
      clrP       = 1'b0;
      ldP        = 1'b0;
      decB       = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = LDA;
            end
         end
         LDA: begin
            ldA        = 1'b1;
            state_next = LDB;
         end
         LDB: begin
            ldB        = 1'b1;
            clrP       = 1'b1;
            state_next = ACC;
         end
         ACC: begin
            if (eqz) begin
               state_next = DONE;
            end else begin
               ldP  = 1'b1;
               decB = 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

`ifdef MUL_CTRL_CYCLE_CNT_EN
   logic [15:0] cnt;

   // Counts accumulate cycles of the current operation; held after done until the next LDB.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 16'd0;
      end else if (state == LDB) begin
         cnt <= 16'd0;
      end else if (state == ACC && !eqz) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign acc_cycles = cnt;
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - self-checking bench for mul_ctrl with an attached datapath
module tb_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        eqz;
   logic        ldA, ldB, clrP, ldP, decB, busy, done;
   logic [15:0] acc_cycles;

   logic [15:0] a_op = 16'd0;
   logic [15:0] b_op = 16'd0;
   logic [15:0] a_reg = 16'd0;
   logic [15:0] b_reg = 16'd0;
   logic [15:0] p_reg = 16'd0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .eqz   (eqz),
      .ldA   (ldA),
      .ldB   (ldB),
      .clrP  (clrP),
      .ldP   (ldP),
      .decB  (decB),
      .busy  (busy),
`ifdef MUL_CTRL_CYCLE_CNT_EN
      .done  (done),
      .acc_cycles (acc_cycles)
`else
      .done  (done)
`endif
   );

`ifndef MUL_CTRL_CYCLE_CNT_EN
   assign acc_cycles = 16'd0;
`endif

   // Datapath: A register, B down-counter, P accumulator
   assign eqz = (b_reg == 16'd0);
   always @(posedge clk) begin
      if (ldA)  a_reg <= a_op;
      if (ldB)  b_reg <= b_op;
      else if (decB) b_reg <= b_reg - 16'd1;
      if (clrP) p_reg <= 16'd0;
      else if (ldP) p_reg <= p_reg + a_reg;
   end

   function automatic logic [15:0] model_product(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] full;
      full = {16'd0, a} * {16'd0, b};
      return full[15:0];
   endfunction

   task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string tag);
      int k, done_at, ldp_cnt, excl_bad, busy_bad, limit;
      logic [15:0] exp_p;
      exp_p    = model_product(a, b);
      limit    = 4 + int'(b) + 20;
      done_at  = -1;
      ldp_cnt  = 0;
      excl_bad = 0;
      busy_bad = 0;
      @(negedge clk);
      a_op = a; b_op = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      checks++;
      if (ldA !== 1'b1) begin
         errors++; $display("FAIL %s lda_cycle1 got %b want 1", tag, ldA);
      end
      while (done_at < 0 && k <= limit) begin
         if (k == 2) begin
            checks++;
            if ({ldB, clrP} !== 2'b11) begin
               errors++; $display("FAIL %s ldb_clrp got %b want 11", tag, {ldB, clrP});
            end
         end
         if (int'(ldA) + int'(ldB) + int'(ldP) > 1) excl_bad++;
         if (busy !== 1'b1) busy_bad++;
         if (ldP === 1'b1) ldp_cnt++;
         if (done === 1'b1) done_at = k;
         else begin
            @(negedge clk);
            k++;
         end
      end
      checks++;
      if (done_at != 4 + int'(b)) begin
         errors++; $display("FAIL %s latency got %0d want %0d", tag, done_at, 4 + int'(b));
      end
      checks++;
      if (ldp_cnt != int'(b)) begin
         errors++; $display("FAIL %s ldp_pulses got %0d want %0d", tag, ldp_cnt, b);
      end
      checks++;
      if (excl_bad != 0 || busy_bad != 0) begin
         errors++; $display("FAIL %s excl_busy got %0d/%0d want 0/0", tag, excl_bad, busy_bad);
      end
      checks++;
      if (p_reg !== exp_p) begin
         errors++; $display("FAIL %s product got %0d want %0d", tag, p_reg, exp_p);
      end
`ifdef MUL_CTRL_CYCLE_CNT_EN
      checks++;
      if (acc_cycles !== b) begin
         errors++; $display("FAIL %s acc_cycles got %0d want %0d", tag, acc_cycles, b);
      end
`endif
      @(negedge clk);
      checks++;
      if ({ldA, ldB, clrP, ldP, decB, busy, done} !== 7'b0 || p_reg !== exp_p) begin
         errors++; $display("FAIL %s post_done got %b p=%0d want 0000000 p=%0d", tag,
                            {ldA, ldB, clrP, ldP, decB, busy, done}, p_reg, exp_p);
      end
`ifdef MUL_CTRL_CYCLE_CNT_EN
      checks++;
      if (acc_cycles !== b) begin
         errors++; $display("FAIL %s acc_hold got %0d want %0d", tag, acc_cycles, b);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ldA, ldB, clrP, ldP, decB, busy, done} !== 7'b0 || acc_cycles !== 16'd0) begin
         errors++; $display("FAIL reset_outputs got %b acc=%0d want 0000000 acc=0",
                            {ldA, ldB, clrP, ldP, decB, busy, done}, acc_cycles);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ldA !== 1'b0) begin
         errors++; $display("FAIL reset_idle got busy=%b lda=%b want 0 0", busy, ldA);
      end
   endtask

   task automatic test_directed();
      run_mul(16'd5,   16'd3,   "a5b3");
      run_mul(16'd7,   16'd0,   "a7b0");
      run_mul(16'd0,   16'd4,   "a0b4");
      run_mul(16'd300, 16'd300, "a300b300");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_mul(16'($urandom), 16'($urandom_range(0, 40)), "random");
      end
   endtask

   task automatic test_reset_mid_acc();
      int seen_done;
      @(negedge clk);
      a_op = 16'd5; b_op = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ldP !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midacc_second_acc got ldp=%b busy=%b want 1 1", ldP, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ldA, ldB, clrP, ldP, decB, busy, done} !== 7'b0 || acc_cycles !== 16'd0) begin
         errors++; $display("FAIL midacc_reset got %b acc=%0d want 0000000 acc=0",
                            {ldA, ldB, clrP, ldP, decB, busy, done}, acc_cycles);
      end
      rst = 1'b0;
      seen_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++; $display("FAIL midacc_no_done got %0d active cycles want 0", seen_done);
      end
      run_mul(16'd2, 16'd2, "after_reset");
   endtask

   task automatic test_back_to_back();
      int k, n_done, n_lda;
      int done_k[$];
      int lda_k[$];
      logic [15:0] p_at[$];
      int idle_bad;
      @(negedge clk);
      a_op = 16'd3; b_op = 16'd2; start = 1'b1;
      idle_bad = 0;
      for (k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (ldA === 1'b1) lda_k.push_back(k);
         if (done === 1'b1) begin
            done_k.push_back(k);
            p_at.push_back(p_reg);
         end
         if (k == 7 && (busy !== 1'b0 || ldA !== 1'b0)) idle_bad++;
      end
      start = 1'b0;
      n_done = done_k.size();
      n_lda  = lda_k.size();
      checks++;
      if (n_done != 2 || done_k[0] != 6 || done_k[1] != 13) begin
         errors++; $display("FAIL b2b_done_cycles got n=%0d first=%0d second=%0d want 2 6 13",
                            n_done, (n_done > 0) ? done_k[0] : -1, (n_done > 1) ? done_k[1] : -1);
      end
      checks++;
      if (n_lda != 2 || lda_k[0] != 1 || lda_k[1] != 8) begin
         errors++; $display("FAIL b2b_lda_cycles got n=%0d first=%0d second=%0d want 2 1 8",
                            n_lda, (n_lda > 0) ? lda_k[0] : -1, (n_lda > 1) ? lda_k[1] : -1);
      end
      checks++;
      if (p_at.size() != 2 || p_at[0] !== 16'd6 || p_at[1] !== 16'd6) begin
         errors++; $display("FAIL b2b_products got n=%0d want two results of 6", p_at.size());
      end
      checks++;
      if (idle_bad != 0) begin
         errors++; $display("FAIL b2b_idle_gap got %0d want 0", idle_bad);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_release got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_reset_mid_acc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
  clk  in  1  rising-edge clock, shared with the A/B/P datapath registers and B down-counter.
  rst  in  1  synchronous, active-high reset.
REQ-002 The remaining ports SHALL be:
  start  in  1  request a multiply; sampled in IDLE only.
  eqz  in  1  B-counter==0 flag from the datapath comparator.
  ldA  out  1  load enable for the A register; the datapath captures din at the end of this cycle.
  ldB  out  1  load enable for the B down-counter; the datapath captures din at the end of this cycle.
  clrP  out  1  synchronous clear for the P register.
  ldP  out  1  load enable for the P register; P captures A+P.
  decB  out  1  decrement enable for the B down-counter.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle pulse; P holds the final product.

Function
REQ-003 The FSM SHALL have five states, encoded in 3 bits: IDLE, LDA, LDB, ACC, DONE.
REQ-004 In IDLE, start=1 SHALL cause a transition to LDA; otherwise the FSM SHALL stay in IDLE.
REQ-005 In LDA, ldA SHALL be 1, and the next state SHALL be LDB unconditionally.
REQ-006 In LDB, ldB and clrP SHALL both be 1, and the next state SHALL be ACC unconditionally.
REQ-007 In ACC, eqz SHALL be decoded combinationally (Mealy):
  - eqz=0: ldP=1 and decB=1, and the FSM stays in ACC.
  - eqz=1: ldP=0 and decB=0, and the next state is DONE.
REQ-008 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-009 Every output not listed for a state SHALL be 0; no two of ldA, ldB and ldP SHALL ever be high in the same cycle.
REQ-010 start SHALL be ignored in LDA, LDB, ACC and DONE; a start held high through DONE SHALL begin a new operation from IDLE on the following cycle.
REQ-011 For operand B=n, done SHALL assert exactly 4+n cycles after the edge at which start was sampled in IDLE.
REQ-012 B=0 SHALL produce zero ldP/decB pulses and a final P=0; A=0 SHALL still iterate n times and produce P=0.
REQ-013 Product width rules SHALL be those of the datapath: 16-bit P, wrapping modulo 2^16; the controller does not detect overflow.
REQ-014 After done, ldP, decB and clrP SHALL remain 0 until the next LDB, so that P is stable for the consumer.

Reset
REQ-015 When rst=1 at a rising edge, the state SHALL become IDLE.
REQ-016 In the cycle after any rst=1 edge, all outputs SHALL be 0.
REQ-017 Reset SHALL take priority over start and eqz.
REQ-018 Reset in mid-ACC SHALL abort the operation; datapath contents are then undefined until the next LDB.
REQ-019 No output SHALL depend on rst combinationally.

Configuration
REQ-020 Macro MUL_CTRL_CYCLE_CNT_EN SHALL control the cycle counter:
  - Defined: the block adds output acc_cycles [15:0]. acc_cycles is cleared to 0 in LDB, increments by 1 in each ACC cycle with eqz=0, and holds its value otherwise, including after done until the next LDB. It resets to 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

Verification
REQ-021 The bench SHALL cover the following scenarios with the datapath attached:
  - A=5, B=3: start pulse -> 3 ldP/decB pulses; done 7 cycles after start; P=15; acc_cycles=3.
  - A=7, B=0: start -> no ldP pulses; done 4 cycles after start; P=0; acc_cycles=0.
  - A=0, B=4: start -> 4 ldP pulses; P=0; done 8 cycles after start.
  - A=300, B=300: P=90000 mod 65536 = 24464; done 304 cycles after start.
  - A=5, B=3, rst=1 on the 2nd ACC cycle: next cycle state=IDLE, all outputs 0, no done; a following start with A=2, B=2 gives P=4.
  - start held high continuously with A=3, B=2: start is ignored while busy; done pulses one cycle; IDLE then immediately LDA; back-to-back results P=6 and P=6.
